// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- shared RV32I decode definitions.
//   * The 11 base-ISA major opcodes.
//   * imm_fmt_e selects which immediate layout imm_gen assembles.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

endpackage

// File: rtl/imm_gen.sv
// imm_gen -- assembles the 32-bit immediate for a given format.
// Ports:
//   ir   in  [31:0]  instruction word
//   fmt  in          immediate format (imm_fmt_e)
//   imm  out [31:0]  immediate; sign bit ir[31] for all formats but U,
//                    zero for IMM_NONE
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] ir,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  // The opcode bits never contribute to an immediate.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^ir[6:0];

  always_comb begin
    imm = 32'h0000_0000;
    case (fmt)
      IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
      IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_U:   imm = {ir[31:12], 12'h000};
      IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/rv32i_id_stage.sv
// rv32i_id_stage -- RV32I instruction decode.
// Purely combinational field split of ir plus one sticky illegal flag.
// Ports:
//   clk, rst        clock; synchronous active-high reset (sticky flag only)
//   ir      [31:0]  instruction word from IF
//   rs1/rs2/rd      register indices (fixed bit positions)
//   opcode/funct3   fixed fields
//   funct7          ir[31:25] for OP, else 0
//   imm     [31:0]  sign-extended immediate selected by opcode
//   illegal         ir is not one of the 11 base opcodes
//   illegal_seen    sticky OR of illegal since the last reset
module rv32i_id_stage
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic        illegal,
  output logic        illegal_seen
);

  imm_fmt_e fmt;
  logic     legal_op;
  logic     illegal_seen_reg;

  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign rd     = ir[11:7];
  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = (ir[6:0] == OP_OP) ? ir[31:25] : 7'b000_0000;

  // Opcode classification: immediate format and legality together.
  always_comb begin
    fmt      = IMM_NONE;
    legal_op = 1'b1;
    case (ir[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_MISC_MEM: fmt = IMM_I;
      OP_STORE:          fmt = IMM_S;
      OP_BRANCH:         fmt = IMM_B;
      OP_LUI, OP_AUIPC:  fmt = IMM_U;
      OP_JAL:            fmt = IMM_J;
      OP_OP:             fmt = IMM_NONE;
      default: begin
        fmt      = IMM_NONE;
        legal_op = 1'b0;
      end
    endcase
  end

  // All listed opcodes end in 2'b11, but the quadrant test is kept
  // explicit so compressed-space words are plainly flagged.
  assign illegal = (ir[1:0] != 2'b11) || !legal_op;

  imm_gen u_imm_gen (
    .ir  (ir),
    .fmt (fmt),
    .imm (imm)
  );

  // Reset wins over a simultaneous illegal word.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_seen_reg <= 1'b0;
    end else begin
      illegal_seen_reg <= illegal_seen_reg | illegal;
    end
  end

  assign illegal_seen = illegal_seen_reg;

endmodule

// File: tb/tb_rv32i_id_stage.sv
// Directed testbench for rv32i_id_stage; expected values hand-computed.
module tb_rv32i_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] ir;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        illegal, illegal_seen;

  int n_cmp = 0;
  int n_mis = 0;

  rv32i_id_stage dut (
    .clk          (clk),
    .rst          (rst),
    .ir           (ir),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .imm          (imm),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Apply one word and compare every combinational output.
  task automatic decode(input string name, input logic [31:0] w,
                        input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                        input logic [4:0] e_rd, input logic [6:0] e_op,
                        input logic [2:0] e_f3, input logic [6:0] e_f7,
                        input logic [31:0] e_imm, input logic e_ill);
    ir = w;
    #1;
    check({name, ".rs1"},     32'(rs1),     32'(e_rs1));
    check({name, ".rs2"},     32'(rs2),     32'(e_rs2));
    check({name, ".rd"},      32'(rd),      32'(e_rd));
    check({name, ".opcode"},  32'(opcode),  32'(e_op));
    check({name, ".funct3"},  32'(funct3),  32'(e_f3));
    check({name, ".funct7"},  32'(funct7),  32'(e_f7));
    check({name, ".imm"},     imm,          e_imm);
    check({name, ".illegal"}, 32'(illegal), 32'(e_ill));
    $display("decode %-6s ir=%08h imm=%08h illegal=%0b", name, w, imm, illegal);
  endtask

  // Clock one rising edge from a negedge, then sample 1 time unit later.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ir  = 32'h002081B3;
    @(negedge clk);
    edge_step();
    check("reset.seen", 32'(illegal_seen), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //      name      ir            rs1 rs2 rd  opcode    f3 f7     imm           ill
    decode("ADD",    32'h002081B3,  1,  2,  3, 7'h33,  3'd0, 7'h00, 32'h00000000, 1'b0);
    decode("SUB",    32'h402081B3,  1,  2,  3, 7'h33,  3'd0, 7'h20, 32'h00000000, 1'b0);
    decode("ADDI",   32'h80108193,  1,  1,  3, 7'h13,  3'd0, 7'h00, 32'hFFFFF801, 1'b0);
    decode("SRAI",   32'h4030D093,  1,  3,  1, 7'h13,  3'd5, 7'h00, 32'h00000403, 1'b0);
    decode("LW",     32'h7FF0A103,  1, 31,  2, 7'h03,  3'd2, 7'h00, 32'h000007FF, 1'b0);
    decode("SW",     32'hFE512E23,  2,  5, 28, 7'h23,  3'd2, 7'h00, 32'hFFFFFFFC, 1'b0);
    decode("BEQ",    32'hFE208CE3,  1,  2, 25, 7'h63,  3'd0, 7'h00, 32'hFFFFFFF8, 1'b0);
    decode("LUI",    32'h123452B7,  8,  3,  5, 7'h37,  3'd5, 7'h00, 32'h12345000, 1'b0);
    decode("AUIPC",  32'hFFFFF017, 31, 31,  0, 7'h17,  3'd7, 7'h00, 32'hFFFFF000, 1'b0);
    decode("JAL",    32'h001000EF,  0,  1,  1, 7'h6F,  3'd0, 7'h00, 32'h00000800, 1'b0);
    decode("JALR",   32'h00008067,  1,  0,  0, 7'h67,  3'd0, 7'h00, 32'h00000000, 1'b0);
    decode("FENCE",  32'h0FF0000F,  0, 31,  0, 7'h0F,  3'd0, 7'h00, 32'h000000FF, 1'b0);
    decode("ECALL",  32'h00000073,  0,  0,  0, 7'h73,  3'd0, 7'h00, 32'h00000000, 1'b0);

    // Legal words only so far: flag must still be clear.
    @(negedge clk);
    edge_step();
    check("legal.seen", 32'(illegal_seen), 32'd0);

    // Non-11 quadrant and unlisted opcode.
    @(negedge clk);
    decode("Q01",    32'h00000031,  0,  0,  0, 7'h31,  3'd0, 7'h00, 32'h00000000, 1'b1);
    check("Q01.seen_before_edge", 32'(illegal_seen), 32'd0);
    @(negedge clk);
    decode("ZERO",   32'h00000000,  0,  0,  0, 7'h00,  3'd0, 7'h00, 32'h00000000, 1'b1);
    edge_step();
    check("zero.seen", 32'(illegal_seen), 32'd1);

    // Sticky across a legal word.
    @(negedge clk);
    ir = 32'h002081B3;
    edge_step();
    check("sticky.illegal", 32'(illegal), 32'd0);
    check("sticky.seen", 32'(illegal_seen), 32'd1);
    $display("sticky seen=%0b", illegal_seen);

    // One reset edge clears it.
    @(negedge clk);
    rst = 1'b1;
    edge_step();
    check("clear.seen", 32'(illegal_seen), 32'd0);

    // Reset priority over a simultaneous illegal word.
    @(negedge clk);
    ir = 32'hFFFFFFFF;
    edge_step();
    check("prio.illegal", 32'(illegal), 32'd1);
    check("prio.seen", 32'(illegal_seen), 32'd0);
    check("prio.imm", imm, 32'h00000000);
    $display("prio rst=1 ir=%08h illegal=%0b seen=%0b", ir, illegal, illegal_seen);

    // Release reset with the illegal word still present.
    @(negedge clk);
    rst = 1'b0;
    edge_step();
    check("release.seen", 32'(illegal_seen), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rv32i_id_stage.md
Name: rv32i_id_stage

Overview:
- RV32I instruction-decode stage: splits a 32-bit instruction word into register indices, opcode and function fields, and a sign-extended 32-bit immediate.
- Sits between the IF stage (drives `ir`) and the register file / EX stage (consume the fields).
- The decode path is purely combinational, with zero latency.
- The only state is a sticky illegal-instruction flag, clocked by `clk` and cleared by `rst`.

Parameters:
- None. Widths are fixed by RV32I: XLEN = 32, register index = 5 bits.

Ports:
- clk  input  1  clock; the sticky flag updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- ir  input  32  instruction word
- rs1  output  5  source register 1 index
- rs2  output  5  source register 2 index
- rd  output  5  destination register index
- opcode  output  7  major opcode
- funct3  output  3  minor function field
- funct7  output  7  R-type function field
- imm  output  32  sign-extended immediate
- illegal  output  1  current `ir` is not a valid RV32I base opcode
- illegal_seen  output  1  sticky: an illegal `ir` has been seen since reset

Behaviour:
- Combinational outputs follow `ir` with no clock dependence: rs1, rs2, rd, opcode, funct3, funct7, imm, illegal.
- Fixed field extraction, independent of format:
  - rs1 = ir[19:15]
  - rs2 = ir[24:20]
  - rd = ir[11:7]
  - opcode = ir[6:0]
  - funct3 = ir[14:12]
- funct7 = ir[31:25] only when opcode = 0110011 (OP). Otherwise funct7 = 0.
- imm is selected by opcode, with sign bit ir[31] in every format except U:
  - I-type (LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011, MISC-MEM 0001111): sext(ir[31:20]). Shift-immediates are not special-cased; imm carries ir[31:20] raw.
  - S-type (STORE 0100011): sext({ir[31:25], ir[11:7]}).
  - B-type (BRANCH 1100011): sext({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}).
  - U-type (LUI 0110111, AUIPC 0010111): {ir[31:12], 12'h000}.
  - J-type (JAL 1101111): sext({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}).
  - R-type (OP) and any unlisted opcode: imm = 32'h0000_0000.
- illegal = 1 when ir[1:0] != 2'b11, or when opcode is not one of the 11 opcodes listed above. funct3/funct7 legality is not checked here.
- illegal_seen:
  - reset value 0; on a rising edge with rst = 1 it is forced to 0, and reset has priority over a simultaneous illegal `ir`.
  - otherwise, on each rising edge, illegal_seen <= illegal_seen | illegal.
  - once set, it stays set until the next reset.
- No X may reach any output for a known `ir`. Combinational outputs are defined during reset as well.

Decomposition:
- Shared package `rv32i_pkg` holds:
  - the 11 opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_MISC_MEM, OP_SYSTEM);
  - an immediate-format enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE).
- One natural sub-module, `imm_gen`: inputs ir[31:0] and the format select, output imm[31:0].
- Opcode-to-format classification and illegal detection stay in the top module.

Test Plan:
- ADD x3,x1,x2: ir = 32'h002081B3 -> rs1=1, rs2=2, rd=3, opcode=0110011, funct3=000, funct7=0000000, imm=0, illegal=0.
- ADDI x3,x1,0x801: ir = 32'h80108193 -> rs1=1, rd=3, opcode=0010011, funct3=000, funct7=0, imm=32'hFFFFF801.
- Store and branch:
  - SW x5,-4(x2): ir = 32'hFE512E23 -> rs1=2, rs2=5, funct3=010, imm=32'hFFFFFFFC.
  - BEQ x1,x2,-8: ir = 32'hFE208CE3 -> rs1=1, rs2=2, imm=32'hFFFFFFF8.
- U- and J-types:
  - LUI x5,0x12345: ir = 32'h123452B7 -> rd=5, imm=32'h12345000.
  - JAL x1,+2048: ir = 32'h001000EF -> rd=1, imm=32'h00000800.
- Illegal and sticky flag:
  - After reset, ir = 32'h00000000 -> illegal=1 immediately; illegal_seen=1 after the next edge.
  - Then ir = 32'h002081B3 -> illegal=0, illegal_seen stays 1.
  - Assert rst for one edge -> illegal_seen=0.
- Reset priority: rst=1 together with ir = 32'hFFFFFFFF (illegal) at an edge -> illegal_seen=0, illegal=1.
